// File: rtl/wb_status_pkg.sv
// wb_status_pkg: register indices and FSM states shared by the status reader.
package wb_status_pkg;
  localparam logic [1:0] REG_LIVE  = 2'd0;
  localparam logic [1:0] REG_EVENT = 2'd1;
  localparam logic [1:0] REG_EVCNT = 2'd2;
  localparam logic [1:0] REG_ID    = 2'd3;
  typedef enum logic {IDLE, ACK} state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with clear; clr with inc restarts at 1.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);
  logic [CNT_WIDTH-1:0] count_q, count_d;
  always_comb begin
    count_d = count_q;
    if (clr) count_d = {{(CNT_WIDTH-1){1'b0}}, inc};
    else if (inc && !(&count_q)) count_d = count_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/wb_status_reader.sv
// wb_status_reader: Wishbone classic read-only status slave with
// live status, read-to-clear sticky events, saturating event counter and ID.
module wb_status_reader
  import wb_status_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               ADDR_WIDTH = 4,
  parameter int               CNT_WIDTH  = 16,
  parameter logic [WIDTH-1:0] ID_VALUE   = 32'h48524D31,
  parameter logic [WIDTH-1:0] IRQ_MASK   = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [WIDTH-1:0]      wb_dat_i,
  input  logic [WIDTH/8-1:0]    wb_sel_i,
  output logic [WIDTH-1:0]      wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [WIDTH-1:0]      status_in,
  input  logic [WIDTH-1:0]      event_in,
  output logic                  irq_o
);
  state_e               state_q, state_d;
  logic [WIDTH-1:0]     dat_q, dat_d, ev_q, ev_d, rdata;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           idx;
  logic                 accept, rd, clr_ev, clr_cnt;
  logic                 unused_bits;
  assign unused_bits = ^{wb_dat_i, wb_sel_i, wb_adr_i};
  assign idx     = wb_adr_i[3:2];
  assign accept  = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
  assign rd      = accept && !wb_we_i;
  assign clr_ev  = rd && (idx == REG_EVENT);
  assign clr_cnt = rd && (idx == REG_EVCNT);
  always_comb begin
    rdata = '0;
    rdata[CNT_WIDTH-1:0] = cnt;
    rdata = (idx == REG_LIVE)  ? status_in :
            (idx == REG_EVENT) ? ev_q :
            (idx == REG_ID)    ? ID_VALUE : rdata;
  end
  // Data is loaded only on a read accept, so it falls back to 0 with the ack.
  always_comb begin
    state_d = accept ? ACK : IDLE;
    dat_d   = rd ? rdata : '0;
    ev_d    = (ev_q & ~{WIDTH{clr_ev}}) | event_in;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      ev_q    <= ev_d;
    end
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (|event_in),
    .clr  (clr_cnt),
    .count(cnt)
  );
  assign wb_ack_o = (state_q == ACK);
  assign wb_dat_o = dat_q;
  assign irq_o    = |(ev_q & IRQ_MASK);
endmodule

// File: tb/tb_wb_status_reader.sv
// tb_wb_status_reader: scoreboard bench for wb_status_reader.
module tb_wb_status_reader;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0;
  logic [31:0] wdat = '0, status = 32'hA5A5_0F0F, ev = '0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat;
  logic        ack, irq;
  logic [31:0] exp_q[$];
  int          errs = 0, checks = 0;

  wb_status_reader dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat),
    .wb_ack_o(ack), .status_in(status), .event_in(ev), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus(input string tag, input logic w, input logic [3:0] a,
                     input logic [31:0] wd, input logic [31:0] e, input logic [31:0] exp);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = wd; ev = e;
    exp_q.push_back(exp);
    check({tag, "_noack_pre"}, {31'b0, ack}, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0; ev = '0;
    check({tag, "_ack"}, {31'b0, ack}, 32'd1);
    check({tag, "_dat"}, dat, exp_q.pop_front());
    @(negedge clk);
    check({tag, "_ack_drop"}, {31'b0, ack}, 32'd0);
    check({tag, "_dat_idle"}, dat, 32'd0);
  endtask

  task automatic pulse(input logic [31:0] e);
    @(negedge clk); ev = e;
    @(negedge clk); ev = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    bus("id", 1'b0, 4'hC, '0, '0, 32'h48524D31);
    check("id_irq", {31'b0, irq}, 32'd0);
    bus("live", 1'b0, 4'h0, '0, '0, 32'hA5A5_0F0F);
    pulse(32'h5);
    check("irq_set", {31'b0, irq}, 32'd1);
    bus("ev5", 1'b0, 4'h4, '0, '0, 32'h5);
    check("irq_clr", {31'b0, irq}, 32'd0);
    bus("ev5_again", 1'b0, 4'h4, '0, '0, 32'h0);
    pulse(32'h1);
    bus("ev1_race", 1'b0, 4'h4, '0, 32'h8, 32'h1);
    bus("ev8_kept", 1'b0, 4'h4, '0, '0, 32'h8);
    bus("cnt3", 1'b0, 4'h8, '0, 32'h4, 32'd3);
    bus("cnt_restart", 1'b0, 4'h8, '0, '0, 32'd1);
    bus("ev4", 1'b0, 4'h4, '0, '0, 32'h4);
    pulse(32'h2);
    bus("wr_ev", 1'b1, 4'h4, 32'hFFFF_FFFF, '0, 32'h0);
    bus("ev2_after_wr", 1'b0, 4'h4, '0, '0, 32'h2);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 4'hC;
    @(negedge clk); check("b2b_ack1", {31'b0, ack}, 32'd1);
    @(negedge clk); check("b2b_gap", {31'b0, ack}, 32'd0);
    @(negedge clk); check("b2b_ack2", {31'b0, ack}, 32'd1);
    check("b2b_dat2", dat, 32'h48524D31);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    ev = 32'h1;
    repeat (70000) @(negedge clk);
    ev = '0;
    bus("cnt_sat", 1'b0, 4'h8, '0, '0, 32'h0000_FFFF);
    bus("cnt_zero", 1'b0, 4'h8, '0, '0, 32'h0);
    pulse(32'h2);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 4'h4;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    check("rst_mid_ack_pre", {31'b0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", {31'b0, ack}, 32'd0);
    check("rst_mid_dat", dat, 32'd0);
    check("rst_mid_irq", {31'b0, irq}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bus("post_rst_ev", 1'b0, 4'h4, '0, '0, 32'h0);
    bus("post_rst_cnt", 1'b0, 4'h8, '0, '0, 32'h0);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
